// File: rtl/pixel_mixer_pipe.sv
// Two-stage pipelined BG/sprite pixel mixer: S1 arbitrates sprite slots, S2 resolves BG priority.
// Optional per-line sprite-win statistics are enabled by defining PIXEL_MIXER_PIPE_STATS_EN.
module pixel_mixer_pipe #(
    parameter int NUM_SP = 4,
    parameter int PAL_W = 3,
    parameter int LINE_W = 160,
    localparam int PIX_W = PAL_W + 3,
    localparam int X_W = $clog2(LINE_W)
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    flush,
    input  logic                    bg_enable,
    input  logic                    sp_master_priority,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PIX_W-1:0]        bg_pixel,
    input  logic [NUM_SP*PIX_W-1:0] sp_pixel,
    input  logic [NUM_SP-1:0]       sp_slot_valid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PIX_W-1:0]        mix_pixel,
    output logic [X_W-1:0]          out_x,
    output logic                    out_last
`ifdef PIXEL_MIXER_PIPE_STATS_EN
    ,
    output logic [X_W:0]            sp_count,
    output logic                    sp_count_valid
`endif
);

    localparam logic [X_W-1:0] LAST_X = X_W'(LINE_W - 1);

    logic             s1_valid_q, s1_hit_q;
    logic [PIX_W-1:0] s1_sp_q, s1_bg_q;
    logic             s2_valid_q, out_last_q;
    logic [PIX_W-1:0] mix_q, mix_d;
    logic [X_W-1:0]   out_x_q, next_x_q, next_x_d;
    logic             s1_adv;
    logic             arb_hit;
    logic [PIX_W-1:0] arb_word;
    logic [1:0]       bg_col_eff;
    logic             bg_prio_eff, sp_wins;

    // A beat moves on valid & ready; a stage may load while its old content leaves the same cycle.
    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;

    // Scan from the top slot down so the lowest opaque valid slot is the one left standing.
    always_comb begin
        arb_hit  = 1'b0;
        arb_word = '0;
        for (int k = NUM_SP - 1; k >= 0; k--) begin
            if (sp_slot_valid[k] && (sp_pixel[k*PIX_W +: 2] != 2'b00)) begin
                arb_hit  = 1'b1;
                arb_word = sp_pixel[k*PIX_W +: PIX_W];
            end
        end
    end

    always_comb begin
        bg_col_eff  = bg_enable ? s1_bg_q[1:0] : 2'b00;
        bg_prio_eff = bg_enable && s1_bg_q[PIX_W-1];
        sp_wins     = s1_hit_q && ((bg_col_eff == 2'b00) || sp_master_priority
                                   || !(bg_prio_eff || s1_sp_q[PIX_W-1]));
        mix_d       = sp_wins ? {1'b1, s1_sp_q[PIX_W-2:0]}
                              : {1'b0, s1_bg_q[PIX_W-2:2], bg_col_eff};
        next_x_d    = (next_x_q == LAST_X) ? '0 : next_x_q + 1'b1;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_sp_q    <= '0;
            s1_bg_q    <= '0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_hit_q <= arb_hit;
                s1_sp_q  <= arb_word;
                s1_bg_q  <= bg_pixel;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s2_valid_q <= 1'b0;
            mix_q      <= '0;
            out_x_q    <= '0;
            out_last_q <= 1'b0;
            next_x_q   <= '0;
        end else if (flush) begin
            s2_valid_q <= 1'b0;
            next_x_q   <= '0;
        end else if (s1_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                mix_q      <= mix_d;
                out_x_q    <= next_x_q;
                out_last_q <= (next_x_q == LAST_X);
                next_x_q   <= next_x_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign mix_pixel = mix_q;
    assign out_x     = out_x_q;
    assign out_last  = out_last_q;

`ifdef PIXEL_MIXER_PIPE_STATS_EN
    logic         out_fire;
    logic [X_W:0] sp_cnt_q, sp_count_q;
    logic         sp_count_valid_q;

    assign out_fire = s2_valid_q && out_ready;

    // The line total includes the last pixel itself, hence the add on the latch path.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sp_cnt_q         <= '0;
            sp_count_q       <= '0;
            sp_count_valid_q <= 1'b0;
        end else if (flush) begin
            sp_cnt_q         <= '0;
            sp_count_valid_q <= 1'b0;
        end else begin
            sp_count_valid_q <= 1'b0;
            if (out_fire) begin
                if (out_last_q) begin
                    sp_count_q       <= sp_cnt_q + (X_W+1)'(mix_q[PIX_W-1]);
                    sp_count_valid_q <= 1'b1;
                    sp_cnt_q         <= '0;
                end else begin
                    sp_cnt_q <= sp_cnt_q + (X_W+1)'(mix_q[PIX_W-1]);
                end
            end
        end
    end

    assign sp_count       = sp_count_q;
    assign sp_count_valid = sp_count_valid_q;
`endif

endmodule

// File: tb/tb_pixel_mixer_pipe.sv
// Directed bench for pixel_mixer_pipe: vector table, latency, backpressure, line wrap and flush.
module tb_pixel_mixer_pipe;

    localparam int NUM_SP = 4;
    localparam int PAL_W  = 3;
    localparam int LINE_W = 160;
    localparam int PIX_W  = PAL_W + 3;
    localparam int X_W    = 8;
    localparam int W      = PIX_W + X_W + 1;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic flush = 1'b0, bg_enable = 1'b1, sp_master_priority = 1'b0;
    logic in_valid = 1'b0, in_ready;
    logic [PIX_W-1:0] bg_pixel = '0;
    logic [NUM_SP*PIX_W-1:0] sp_pixel = '0;
    logic [NUM_SP-1:0] sp_slot_valid = '0;
    logic out_valid, out_ready = 1'b1;
    logic [PIX_W-1:0] mix_pixel;
    logic [X_W-1:0] out_x;
    logic out_last;
`ifdef PIXEL_MIXER_PIPE_STATS_EN
    logic [X_W:0] sp_count;
    logic sp_count_valid;
    int stat_pulses = 0;
`endif

    pixel_mixer_pipe #(.NUM_SP(NUM_SP), .PAL_W(PAL_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .n_reset(n_reset), .flush(flush), .bg_enable(bg_enable),
        .sp_master_priority(sp_master_priority), .in_valid(in_valid), .in_ready(in_ready),
        .bg_pixel(bg_pixel), .sp_pixel(sp_pixel), .sp_slot_valid(sp_slot_valid),
        .out_valid(out_valid), .out_ready(out_ready), .mix_pixel(mix_pixel),
        .out_x(out_x), .out_last(out_last)
`ifdef PIXEL_MIXER_PIPE_STATS_EN
        , .sp_count(sp_count), .sp_count_valid(sp_count_valid)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0, passes = 0;
    logic [W-1:0] exp_q[$];
    int model_x = 0;
    logic mon_en = 1'b0;
    logic hold_pending = 1'b0;
    logic [PIX_W+X_W-1:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passes++;
    endtask

    function automatic logic [PIX_W-1:0] px(input logic p, input logic [2:0] pal, input logic [1:0] col);
        return {p, pal, col};
    endfunction

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (mon_en) begin
            logic [W-1:0] e;
            check("in_ready", 32'(in_ready),
                  32'(!(out_valid && !out_ready && exp_q.size() >= 2)));
            if (hold_pending) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({mix_pixel, out_x}), 32'(held));
                hold_pending = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_out: got pix %0h x %0d expected none", mix_pixel, out_x);
                end else begin
                    e = exp_q.pop_front();
                    check("mix_pixel", 32'(mix_pixel), 32'(e[W-1 -: PIX_W]));
                    check("out_x", 32'(out_x), 32'(e[X_W:1]));
                    check("out_last", 32'(out_last), 32'(e[0]));
                end
            end else if (out_valid && !out_ready) begin
                hold_pending = 1'b1;
                held = {mix_pixel, out_x};
            end
        end
    end

`ifdef PIXEL_MIXER_PIPE_STATS_EN
    always @(negedge clk) if (sp_count_valid) stat_pulses++;
`endif

    // driver tasks: all input changes happen 1 time unit after a rising edge
    task automatic send(input logic [PIX_W-1:0] bg, input logic [NUM_SP*PIX_W-1:0] sp,
                        input logic [NUM_SP-1:0] sv, input logic [PIX_W-1:0] exp_pix);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        bg_pixel = bg; sp_pixel = sp; sp_slot_valid = sv; in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            $display("FAIL send_timeout: got no accept expected accept");
        end else begin
            exp_q.push_back({exp_pix, X_W'(model_x), model_x == LINE_W - 1});
            model_x = (model_x == LINE_W - 1) ? 0 : model_x + 1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        hold_pending = 1'b0;
        model_x = 0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic en;
        logic master;
        logic [PIX_W-1:0] bg;
        logic [NUM_SP*PIX_W-1:0] sp;
        logic [NUM_SP-1:0] sv;
        logic [PIX_W-1:0] exp_pix;
    } vec_t;

    vec_t vecs[10];
    logic done;

    initial begin
        // vector table: sp slots packed {slot3, slot2, slot1, slot0}
        vecs[0] = '{1, 0, px(1,2,1), {18'd0, px(0,4,3)}, 4'b0001, px(0,2,1)};
        vecs[1] = '{1, 1, px(1,2,1), {18'd0, px(0,4,3)}, 4'b0001, px(1,4,3)};
        vecs[2] = '{1, 0, px(1,2,0), {18'd0, px(0,4,3)}, 4'b0001, px(1,4,3)};
        vecs[3] = '{0, 0, px(1,2,3), {18'd0, px(0,4,3)}, 4'b0001, px(1,4,3)};
        vecs[4] = '{1, 0, px(0,2,1), {px(0,7,3), px(0,6,3), px(0,3,1), px(0,1,0)}, 4'b0111, px(1,3,1)};
        vecs[5] = '{1, 0, px(0,2,1), {px(0,7,3), px(0,6,3), px(0,3,1), px(0,1,2)}, 4'b0000, px(0,2,1)};
        vecs[6] = '{1, 0, px(0,2,1), {18'd0, px(1,4,3)}, 4'b0001, px(0,2,1)};
        vecs[7] = '{1, 0, px(0,2,1), {px(0,7,2), 12'd0, px(0,1,3)}, 4'b1000, px(1,7,2)};
        vecs[8] = '{0, 0, px(1,5,3), 24'd0, 4'b0000, px(0,5,0)};
        vecs[9] = '{1, 0, px(0,2,1), {18'd0, px(0,4,0)}, 4'b0001, px(0,2,1)};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mix", 32'(mix_pixel), 32'd0);
        check("rst_out_x", 32'(out_x), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        mon_en = 1'b1;

        // first beat: accepted on E1, out_valid after E2
        bg_pixel = px(0,2,1); sp_pixel = {18'd0, px(0,5,2)}; sp_slot_valid = 4'b0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back({px(1,5,2), 8'd0, 1'b0});
        model_x = 1;
        check("lat_cycle1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_cycle2", 32'(out_valid), 32'd1);
        check("lat_mix", 32'(mix_pixel), 32'(px(1,5,2)));
        drain();

        // priority / arbitration table, one beat at a time so controls are stable at S1->S2
        for (int i = 0; i < 10; i++) begin
            bg_enable = vecs[i].en;
            sp_master_priority = vecs[i].master;
            send(vecs[i].bg, vecs[i].sp, vecs[i].sv, vecs[i].exp_pix);
            drain();
        end
        bg_enable = 1'b1;
        sp_master_priority = 1'b0;

        // backpressure: 10 beats with out_ready mostly low
        do_flush();
        done = 1'b0;
        fork
            begin
                for (int x = 0; x < 10; x++) begin
                    logic [2:0] p;
                    p = 3'(x);
                    send(px(0,p,1), 24'd0, 4'b0000, px(0,p,1));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 99) < 40);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // full line plus one: out_last only at 159, then wrap to 0
        do_flush();
        for (int x = 0; x <= LINE_W; x++) begin
            logic [2:0] p;
            p = 3'(x);
            send(px(1,p,2), 24'd0, 4'b0000, px(0,p,2));
        end
        drain();

        // flush mid-line once beat x=57 has been accepted
        while (model_x != 58) send(px(0,1,1), 24'd0, 4'b0000, px(0,1,1));
        do_flush();
        @(posedge clk);
        #1;
        check("post_flush_idle", 32'(out_valid), 32'd0);
        send(px(0,6,3), 24'd0, 4'b0000, px(0,6,3));
        drain();

`ifdef PIXEL_MIXER_PIPE_STATS_EN
        do_flush();
        stat_pulses = 0;
        for (int x = 0; x < LINE_W; x++) begin
            if (x >= 10 && x <= 17) send(px(0,2,1), {18'd0, px(0,4,3)}, 4'b0001, px(1,4,3));
            else send(px(0,2,1), 24'd0, 4'b0000, px(0,2,1));
        end
        drain();
        check("stat_pulses", 32'(stat_pulses), 32'd1);
        check("stat_count", 32'(sp_count), 32'd8);
`endif

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pixel_mixer_pipe.md
Name: pixel_mixer_pipe

Overview:
- Parametrised, pipelined successor to the PPU's combinational BG/sprite pixel mixer.
- Takes one BG pixel plus NUM_SP candidate sprite pixels per beat (slot 0 = highest OAM priority). Arbitrates the sprites, then resolves BG-vs-sprite priority.
- Emits the mixed pixel with an x coordinate and a last-pixel-of-line flag over a valid/ready stream to the LCD output stage.

Parameters:
- NUM_SP, 4, number of overlapping sprite slots presented per pixel (1..10).
- PAL_W, 3, palette-number width in pixel words.
- LINE_W, 160, visible pixels per line; x counter range 0..LINE_W-1.
- PIX_W (localparam), PAL_W+3, pixel word {prio, pal[PAL_W-1:0], col[1:0]}.
- X_W (localparam), $clog2(LINE_W), x counter width.

Ports:
- clk  in  1  PPU clock.
- n_reset  in  1  asynchronous active-low reset.
- flush  in  1  line/mode abort; synchronous clear.
- bg_enable  in  1  0 forces BG colour index to 00 and BG prio to 0 for mixing; BG palette is still passed through.
- sp_master_priority  in  1  1 lets any opaque sprite win over BG.
- in_valid  in  1  input beat valid.
- in_ready  out  1  mixer can accept a beat.
- bg_pixel  in  PIX_W  BG/window pixel; prio = BG attribute priority.
- sp_pixel  in  NUM_SP*PIX_W  slot k at bits [k*PIX_W +: PIX_W]; prio = OAM bg-over-obj flag.
- sp_slot_valid  in  NUM_SP  slot k holds a sprite this pixel.
- out_valid  out  1  mixed pixel valid.
- out_ready  in  1  sink accepts.
- mix_pixel  out  PIX_W  {is_sp, pal, col}.
- out_x  out  X_W  x coordinate of mix_pixel.
- out_last  out  1  out_x == LINE_W-1.

Behaviour:
- Reset (n_reset=0, async):
  - All valid bits, out_valid, out_x, out_last and mix_pixel go to 0.
  - in_ready goes to 1 once reset is released.
- Pipeline has two registered stages, S1 and S2; S2 drives the outputs.
  - Latency is 2 cycles from an accepted input beat to out_valid when there is no stall.
  - Throughput is 1 pixel/cycle.
- Handshake:
  - Transfer occurs when valid&ready are both high.
  - in_ready = !s1_valid | s1_adv, where s1_adv = !s2_valid | out_ready.
  - S2 holds mix_pixel and out_x stable while out_valid & !out_ready. No beat is lost or duplicated under any stall pattern.
- S1, sprite arbitration:
  - Winner is the lowest k with sp_slot_valid[k] and col != 00.
  - Register sp_hit, the winner's word and bg_pixel.
  - If there is no winner, sp_hit=0.
- S2, priority resolution:
  - sp_wins = sp_hit & (bg_col==00 | sp_master_priority | !(bg_prio | sp_prio)).
  - bg_col and bg_prio are taken as 0 when bg_enable=0.
  - mix_pixel = sp_wins ? {1, sp_pal, sp_col} : {0, bg_pal, bg_col}.
  - bg_enable and sp_master_priority are sampled at the S1→S2 transfer.
- x counter:
  - out_x is assigned at the S1→S2 transfer from an internal next_x.
  - next_x increments per transfer and wraps LINE_W-1 → 0.
  - out_last is registered alongside out_x.
- flush:
  - Synchronous, highest priority.
  - Clears s1_valid, s2_valid and next_x to 0 in the next cycle.
  - An input beat presented in the flush cycle is dropped.
  - in_ready may remain high during flush.
- Simultaneous out-handshake and new S2 load: S2 is overwritten the same cycle (bubble-free).

Optional Feature:
- Macro: PIXEL_MIXER_PIPE_STATS_EN.
- Defined:
  - Adds outputs sp_count [X_W:0] and sp_count_valid.
  - Counts sprite-won pixels across the line, incremented on each output handshake with mix_pixel[PIX_W-1]=1.
  - On the out_last handshake, latches the line total into sp_count, pulses sp_count_valid for 1 cycle, and restarts counting from 0.
  - Reset and flush clear the internal counter; sp_count is held after flush.
- Undefined: no extra ports or logic. Mixing behaviour is identical either way.

Test Plan:
- Reset, one beat: bg={0,3'd2,2'b01}, slot0={0,3'd5,2'b10} valid, out_ready=1 → mix_pixel={1,5,10} and out_x=0, out_valid exactly 2 cycles after accept.
- Priority table:
  - bg col=01, bg prio=1, sprite col=11, master=0 → BG wins {0,bg_pal,01}.
  - Same with master=1 → sprite wins.
  - bg col=00, bg prio=1 → sprite wins.
  - bg_enable=0, bg col=11, bg prio=1 → sprite wins.
- Slot arbitration: slot0 col=00, slot1 col=01 pal 3, slot2 col=11 → sprite {1,3,01}. All slots invalid → BG.
- Backpressure: stream x=0..9 with out_ready toggling random (≥50% low) → 10 pixels out, in order, out_x 0..9, values stable during stall; in_ready low only when both stages full and blocked.
- Line wrap/flush:
  - 160 beats → out_last only on out_x=159, next beat out_x=0.
  - flush mid-line at x=57 → pipeline empties, next accepted beat emits out_x=0.
- With PIXEL_MIXER_PIPE_STATS_EN: 160-pixel line with sprites winning on x=10..17 → sp_count=8 with 1-cycle sp_count_valid on the out_last handshake.
